// File: rtl/forward_hazard_unit.sv
// EX-stage forwarding selector generation and load-use stall control.
// Shadows the destinations of in-flight instructions to pick the freshest operand source.
module forward_hazard_unit #(
  parameter int REG_BITS = 5
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic [REG_BITS-1:0] id_dest,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                flush,
  input  logic                mem_wait,
  output logic [1:0]          fwd_a_sel,
  output logic [1:0]          fwd_b_sel,
  output logic                stall,
  output logic                freeze
);

  typedef enum logic {RUN, LOAD_STALL} state_e;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_ALU = 2'b10;

  state_e state_q, state_d;

  logic                ex_valid_q, ex_valid_d;
  logic [REG_BITS-1:0] ex_dest_q, ex_dest_d;
  logic                ex_reg_write_q, ex_reg_write_d;
  logic                ex_mem_read_q, ex_mem_read_d;

  // The WB stage is not shadowed: a WB producer never forwards and never stalls,
  // and a MEM-stage load no longer needs a stall, so MEM keeps no load flag.
  logic                mem_valid_q, mem_valid_d;
  logic [REG_BITS-1:0] mem_dest_q, mem_dest_d;
  logic                mem_reg_write_q, mem_reg_write_d;

  logic [1:0] fwd_a_sel_q, fwd_a_sel_d;
  logic [1:0] fwd_b_sel_q, fwd_b_sel_d;

  logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
  logic load_use, bubble;

  function automatic logic stage_match(input logic v, input logic rw,
                                       input logic [REG_BITS-1:0] dest,
                                       input logic [REG_BITS-1:0] src);
    return v & rw & (dest == src) & (src != '0);
  endfunction

  function automatic logic [1:0] pick_sel(input logic ex_hit, input logic mem_hit);
    if (ex_hit) begin
      return SEL_ALU;
    end else if (mem_hit) begin
      return SEL_WB;
    end
    return SEL_RF;
  endfunction

  assign ex_hit_rs  = stage_match(ex_valid_q, ex_reg_write_q, ex_dest_q, id_rs);
  assign ex_hit_rt  = stage_match(ex_valid_q, ex_reg_write_q, ex_dest_q, id_rt);
  assign mem_hit_rs = stage_match(mem_valid_q, mem_reg_write_q, mem_dest_q, id_rs);
  assign mem_hit_rt = stage_match(mem_valid_q, mem_reg_write_q, mem_dest_q, id_rt);

  assign load_use = ex_valid_q & ex_mem_read_q & (ex_hit_rs | ex_hit_rt) & id_valid & ~flush;
  assign stall    = load_use & (state_q == RUN) & ~mem_wait;
  assign freeze   = mem_wait;
  assign bubble   = stall | flush | ~id_valid;

  assign fwd_a_sel = fwd_a_sel_q;
  assign fwd_b_sel = fwd_b_sel_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:        if (stall) state_d = LOAD_STALL;
      LOAD_STALL: state_d = RUN;
      default:    state_d = RUN;
    endcase

    mem_valid_d     = ex_valid_q;
    mem_dest_d      = ex_dest_q;
    mem_reg_write_d = ex_reg_write_q;

    ex_valid_d     = 1'b0;
    ex_dest_d      = '0;
    ex_reg_write_d = 1'b0;
    ex_mem_read_d  = 1'b0;
    fwd_a_sel_d    = SEL_RF;
    fwd_b_sel_d    = SEL_RF;
    if (!bubble) begin
      ex_valid_d     = 1'b1;
      ex_dest_d      = id_dest;
      ex_reg_write_d = id_reg_write;
      ex_mem_read_d  = id_mem_read;
      fwd_a_sel_d    = pick_sel(ex_hit_rs, mem_hit_rs);
      fwd_b_sel_d    = pick_sel(ex_hit_rt, mem_hit_rt);
    end
  end

  // A busy data memory freezes the whole pipeline, so nothing here advances.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= RUN;
      ex_valid_q      <= 1'b0;
      ex_dest_q       <= '0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      mem_valid_q     <= 1'b0;
      mem_dest_q      <= '0;
      mem_reg_write_q <= 1'b0;
      fwd_a_sel_q     <= SEL_RF;
      fwd_b_sel_q     <= SEL_RF;
    end else if (!mem_wait) begin
      state_q         <= state_d;
      ex_valid_q      <= ex_valid_d;
      ex_dest_q       <= ex_dest_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_mem_read_q   <= ex_mem_read_d;
      mem_valid_q     <= mem_valid_d;
      mem_dest_q      <= mem_dest_d;
      mem_reg_write_q <= mem_reg_write_d;
      fwd_a_sel_q     <= fwd_a_sel_d;
      fwd_b_sel_q     <= fwd_b_sel_d;
    end
  end

endmodule
